// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter: port-id encoding, default widths
// and the in-flight response tag used by the fetch and load paths.
package rom_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_WIDTH      = 32;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter with a one-hot combinational grant; the
// priority pointer moves only when a grant is issued.
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    port_id_e r_prio;

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[0] && (!i_req[1] || r_prio == PORT_FETCH)) begin
            o_gnt[0] = 1'b1;
        end else if (i_req[1]) begin
            o_gnt[1] = 1'b1;
        end
    end

    // The port that just won drops to lowest priority for the next tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= PORT_FETCH;
        end else if (o_gnt[0]) begin
            r_prio <= PORT_DATA;
        end else if (o_gnt[1]) begin
            r_prio <= PORT_FETCH;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between a fetch port and a data port, one
// grant per cycle, with a single-entry in-flight tag steering the response.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_valid,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    output logic                  r0_ready,
    output logic                  r0_rsp_valid,
    output logic [WIDTH-1:0]      r0_rsp_data,
    input  logic                  r1_valid,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic                  r1_ready,
    output logic                  r1_rsp_valid,
    output logic [WIDTH-1:0]      r1_rsp_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]      rom_q
);

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    tag_t                  r_tag;
    logic [WIDTH-1:0]      r_hold0;
    logic [WIDTH-1:0]      r_hold1;

    // Masking requests with rst_n keeps ready low through reset cycles.
    assign w_req = {r1_valid, r0_valid} & {2{rst_n}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign r0_ready   = w_gnt[0];
    assign r1_ready   = w_gnt[1];
    assign w_grant    = |w_gnt;
    assign w_gnt_addr = w_gnt[1] ? r1_addr : r0_addr;
    assign rom_addr   = w_grant ? w_gnt_addr : r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_tag  <= '0;
        end else begin
            r_tag.valid <= w_grant;
            r_tag.port  <= w_gnt[1] ? PORT_DATA : PORT_FETCH;
            if (w_grant) begin
                r_addr <= w_gnt_addr;
            end
        end
    end

    // Gating with rst_n discards a read that was in flight when reset hit.
    assign r0_rsp_valid = rst_n && r_tag.valid && (r_tag.port == PORT_FETCH);
    assign r1_rsp_valid = rst_n && r_tag.valid && (r_tag.port == PORT_DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (r0_rsp_valid) begin
                r_hold0 <= rom_q;
            end
            if (r1_rsp_valid) begin
                r_hold1 <= rom_q;
            end
        end
    end

    assign r0_rsp_data = r0_rsp_valid ? rom_q : r_hold0;
    assign r1_rsp_data = r1_rsp_valid ? rom_q : r_hold1;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios then random traffic, checked
// against a queue-based reference model and a 1-cycle ROM model.
module tb_rom_arbiter;
    import rom_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_valid = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic          r0_ready;
    logic          r0_rsp_valid;
    logic [DW-1:0] r0_rsp_data;
    logic          r1_valid = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic          r1_ready;
    logic          r1_rsp_valid;
    logic [DW-1:0] r1_rsp_data;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
    } req_t;

    int            lastGranted;
    logic [AW-1:0] mLastAddr;
    logic [31:0]   mHold [2];
    req_t          inflight [$];
    int            waitCnt [2];

    rom_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r0_valid     (r0_valid),
        .r0_addr      (r0_addr),
        .r0_ready     (r0_ready),
        .r0_rsp_valid (r0_rsp_valid),
        .r0_rsp_data  (r0_rsp_data),
        .r1_valid     (r1_valid),
        .r1_addr      (r1_addr),
        .r1_ready     (r1_ready),
        .r1_rsp_valid (r1_rsp_valid),
        .r1_rsp_data  (r1_rsp_data),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [AW-1:0] a);
        return 32'h01010101 * {27'd0, a};
    endfunction

    // Synchronous ROM: data for the address sampled at an edge appears after it.
    always @(posedge clk) rom_q <= romWord(rom_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rs, input logic v0, input logic [AW-1:0] a0,
                                 input logic v1, input logic [AW-1:0] a1);
        int            g;
        logic          haveRsp;
        req_t          rsp;
        logic          expV [2];
        logic [31:0]   expD [2];
        logic [AW-1:0] expAddr;
        logic          obsReady [2];
        logic          obsValid [2];

        @(negedge clk);
        rst_n = rs; r0_valid = v0; r0_addr = a0; r1_valid = v1; r1_addr = a1;
        #2;

        haveRsp = 1'b0;
        rsp = '{0, '0};
        if (inflight.size() > 0) begin
            rsp = inflight.pop_front();
            haveRsp = rs;
        end

        g = -1;
        if (rs) begin
            if (v0 && v1) g = (lastGranted == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        expAddr = (g == 0) ? a0 : (g == 1) ? a1 : mLastAddr;
        for (int p = 0; p < 2; p++) begin
            expV[p] = haveRsp && (rsp.port == p);
            expD[p] = expV[p] ? romWord(rsp.addr) : mHold[p];
        end

        checkOutput("r0_ready", {31'd0, r0_ready}, {31'd0, (g == 0)});
        checkOutput("r1_ready", {31'd0, r1_ready}, {31'd0, (g == 1)});
        checkOutput("rom_addr", {27'd0, rom_addr}, {27'd0, expAddr});
        checkOutput("r0_rsp_valid", {31'd0, r0_rsp_valid}, {31'd0, expV[0]});
        checkOutput("r1_rsp_valid", {31'd0, r1_rsp_valid}, {31'd0, expV[1]});
        checkOutput("r0_rsp_data", r0_rsp_data, expD[0]);
        checkOutput("r1_rsp_data", r1_rsp_data, expD[1]);

        obsReady[0] = r0_ready; obsReady[1] = r1_ready;
        obsValid[0] = v0 && rs; obsValid[1] = v1 && rs;
        for (int p = 0; p < 2; p++) begin
            if (!obsValid[p] || obsReady[p]) waitCnt[p] = 0;
            else waitCnt[p]++;
            if (obsValid[p]) checkOutput($sformatf("starve%0d", p), {31'd0, (waitCnt[p] > 1)}, 32'd0);
        end

        @(posedge clk);
        if (!rs) begin
            lastGranted = 1;
            mLastAddr = '0;
            mHold[0] = '0;
            mHold[1] = '0;
            inflight.delete();
        end else begin
            if (haveRsp) mHold[rsp.port] = romWord(rsp.addr);
            if (g >= 0) begin
                lastGranted = g;
                mLastAddr = expAddr;
                inflight.push_back('{g, expAddr});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        lastGranted = 1;
        mLastAddr = '0;
        mHold[0] = '0;
        mHold[1] = '0;
        waitCnt[0] = 0;
        waitCnt[1] = 0;

        // Unchecked first edge brings the DUT registers out of X.
        @(posedge clk);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Single fetch read of address 3.
        applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);

        // Data port alone streams four addresses back to back.
        for (int a = 4; a < 8; a++) applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, AW'(a));
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);

        // Both ports contend; grants must alternate starting with port 0.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 5'd1, 1'b1, 5'd2);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);

        // Grant then idle with changing, ungranted addresses.
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd17, 1'b0, 5'd22);
        applyStimulus(1'b1, 1'b0, 5'd30, 1'b0, 5'd11);
        applyStimulus(1'b1, 1'b0, 5'd2, 1'b0, 5'd5);

        // Reset with a data read in flight, requests held during reset.
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd8);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 5'd6);
        applyStimulus(1'b1, 1'b1, 5'd10, 1'b1, 5'd11);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);

        // Random traffic on both ports.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1,
                          ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)));
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
